// File: rtl/pipeline_result_sequencer.sv
// Collects one job's batch results from a 24-permutation pipeline pack and
// presents the accumulated totals and sticky ECC flag on a valid/ready handshake.
module pipeline_result_sequencer #(
  parameter int unsigned SUM_W         = 72,
  parameter int unsigned COUNT_W       = 37,
  parameter int unsigned BATCH_W       = 16,
  parameter int unsigned GRAB_LATENCY  = 3,
  parameter int unsigned AVAIL_HOLDOFF = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jobStart,
  input  logic [BATCH_W-1:0]         jobBatches,
  output logic                       jobStartIgnored,
  input  logic                       resultsAvailable,
  output logic                       grabResults,
  input  logic [SUM_W-1:0]           pcoeffSum,
  input  logic [COUNT_W-1:0]         pcoeffCount,
  input  logic                       eccStatus,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [SUM_W+BATCH_W-1:0]   outSum,
  output logic [COUNT_W+BATCH_W-1:0] outCount,
  output logic                       outEcc,
  output logic                       busy
);

  localparam int unsigned OSUM_W = SUM_W + BATCH_W;
  localparam int unsigned OCNT_W = COUNT_W + BATCH_W;
  localparam int unsigned LAT_W  = (GRAB_LATENCY > 1) ? $clog2(GRAB_LATENCY) : 1;
  localparam int unsigned HOLD_W = (AVAIL_HOLDOFF > 1) ? $clog2(AVAIL_HOLDOFF) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_AVAIL,
    S_GRAB,
    S_LATENCY,
    S_HOLDOFF,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [BATCH_W-1:0]  rem_q;
  logic [LAT_W-1:0]    lat_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [OSUM_W-1:0]   sum_q;
  logic [OCNT_W-1:0]   cnt_q;
  logic                ecc_q;
  logic                grab_q;
  logic                ign_q;
  logic                valid_q;
  logic                busy_q;

  // Sequencer FSM with registered outputs; reset abandons any in-flight grab.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      lat_q   <= '0;
      hold_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ecc_q   <= 1'b0;
      grab_q  <= 1'b0;
      ign_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      grab_q <= 1'b0;
      ign_q  <= jobStart && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (jobStart) begin
            rem_q  <= jobBatches;
            sum_q  <= '0;
            cnt_q  <= '0;
            ecc_q  <= 1'b0;
            busy_q <= 1'b1;
            state_q <= (jobBatches == '0) ? S_DONE : S_WAIT_AVAIL;
          end
        end
        S_WAIT_AVAIL: begin
          if (resultsAvailable) begin
            state_q <= S_GRAB;
            grab_q  <= 1'b1;
          end
        end
        S_GRAB: begin
          state_q <= S_LATENCY;
          lat_q   <= LAT_W'(GRAB_LATENCY - 1);
        end
        S_LATENCY: begin
          if (lat_q == '0) begin
            sum_q <= sum_q + OSUM_W'(pcoeffSum);
            cnt_q <= cnt_q + OCNT_W'(pcoeffCount);
            ecc_q <= ecc_q | eccStatus;
            rem_q <= rem_q - BATCH_W'(1);
            if (rem_q == BATCH_W'(1)) begin
              state_q <= S_DONE;
            end else if (AVAIL_HOLDOFF == 0) begin
              state_q <= S_WAIT_AVAIL;
            end else begin
              state_q <= S_HOLDOFF;
              hold_q  <= HOLD_W'(AVAIL_HOLDOFF - 1);
            end
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        S_HOLDOFF: begin
          // resultsAvailable may still reflect the batch just taken
          if (hold_q == '0) begin
            state_q <= S_WAIT_AVAIL;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        S_DONE: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (outReady) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign jobStartIgnored = ign_q;
  assign grabResults     = grab_q;
  assign outValid        = valid_q;
  assign outSum          = sum_q;
  assign outCount        = cnt_q;
  assign outEcc          = ecc_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_pipeline_result_sequencer.sv
// Bench for pipeline_result_sequencer: timestamp-based job model plus a pack
// emulator that returns data exactly GRAB_LATENCY cycles after each grab.
module tb_pipeline_result_sequencer;

  localparam int unsigned SUM_W   = 72;
  localparam int unsigned COUNT_W = 37;
  localparam int unsigned BATCH_W = 16;
  localparam int unsigned GL      = 3;
  localparam int unsigned H       = 8;
  localparam int unsigned OS_W    = SUM_W + BATCH_W;
  localparam int unsigned OC_W    = COUNT_W + BATCH_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               jobStart = 1'b0;
  logic [BATCH_W-1:0] jobBatches = '0;
  logic               jobStartIgnored;
  logic               resultsAvailable = 1'b0;
  logic               grabResults;
  logic [SUM_W-1:0]   pcoeffSum = '0;
  logic [COUNT_W-1:0] pcoeffCount = '0;
  logic               eccStatus = 1'b0;
  logic               outValid;
  logic               outReady = 1'b0;
  logic [OS_W-1:0]    outSum;
  logic [OC_W-1:0]    outCount;
  logic               outEcc;
  logic               busy;

  pipeline_result_sequencer #(
    .SUM_W(SUM_W), .COUNT_W(COUNT_W), .BATCH_W(BATCH_W),
    .GRAB_LATENCY(GL), .AVAIL_HOLDOFF(H)
  ) dut (
    .clk(clk), .rst(rst), .jobStart(jobStart), .jobBatches(jobBatches),
    .jobStartIgnored(jobStartIgnored), .resultsAvailable(resultsAvailable),
    .grabResults(grabResults), .pcoeffSum(pcoeffSum), .pcoeffCount(pcoeffCount),
    .eccStatus(eccStatus), .outValid(outValid), .outReady(outReady),
    .outSum(outSum), .outCount(outCount), .outEcc(outEcc), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // staged inputs for the next cycle
  logic               s_rst = 1'b1, s_js = 1'b0, s_av = 1'b0, s_rdy = 1'b0;
  logic [BATCH_W-1:0] s_jb = '0;

  // pack emulator
  logic [SUM_W-1:0]   pk_sum[$];
  logic [COUNT_W-1:0] pk_cnt[$];
  logic               pk_ecc[$];
  int                 del_cyc = -1;
  logic [SUM_W-1:0]   del_sum;
  logic [COUNT_W-1:0] del_cnt;
  logic               del_ecc;

  // observations
  int n_grabs = 0;
  int n_ign = 0;
  int grab_log[$];
  logic last_valid = 1'b0;

  // job model: timestamps of the next interesting cycle
  logic            m_busy = 1'b0, m_done = 1'b0;
  int              m_rem = 0, wait_from = 0, cap_cyc = -1, valid_from = -1;
  logic [OS_W-1:0] m_sum = '0;
  logic [OC_W-1:0] m_cnt = '0;
  logic            m_ecc = 1'b0;
  logic            e_grab = 1'b0, e_ign = 1'b0, e_valid = 1'b0, e_busy = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [SUM_W-1:0] rnd_sum();
    return SUM_W'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [COUNT_W-1:0] rnd_cnt();
    return COUNT_W'({$urandom(), $urandom()});
  endfunction

  task automatic push_pk(input logic [SUM_W-1:0] s, input logic [COUNT_W-1:0] c, input logic e);
    pk_sum.push_back(s);
    pk_cnt.push_back(c);
    pk_ecc.push_back(e);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_done = 1'b0; m_rem = 0; wait_from = 0;
    cap_cyc = -1; valid_from = -1; m_sum = '0; m_cnt = '0; m_ecc = 1'b0;
  endtask

  // Advance the model across the edge that ends cycle cyc.
  task automatic model_step();
    e_grab = 1'b0;
    e_ign  = 1'b0;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (jobStart) begin
        m_busy = 1'b1;
        m_rem  = int'(jobBatches);
        m_sum  = '0; m_cnt = '0; m_ecc = 1'b0;
        if (m_rem == 0) begin
          m_done = 1'b1;
          valid_from = cyc + 2;
        end else begin
          wait_from = cyc + 1;
        end
      end
    end else begin
      e_ign = jobStart;
      if (m_done) begin
        if (cyc >= valid_from && outReady) begin
          m_busy = 1'b0;
          m_done = 1'b0;
          valid_from = -1;
        end
      end else if (cap_cyc == cyc) begin
        m_sum = m_sum + OS_W'(pcoeffSum);
        m_cnt = m_cnt + OC_W'(pcoeffCount);
        m_ecc = m_ecc | eccStatus;
        m_rem = m_rem - 1;
        cap_cyc = -1;
        if (m_rem == 0) begin
          m_done = 1'b1;
          valid_from = cyc + 2;
        end else begin
          wait_from = cyc + 1 + int'(H);
        end
      end else if (cap_cyc < 0 && cyc >= wait_from && resultsAvailable) begin
        e_grab = 1'b1;
        cap_cyc = cyc + 1 + int'(GL);
      end
    end
    e_valid = m_done && (cyc + 1 >= valid_from);
    e_busy  = m_busy;
  endtask

  task automatic tick();
    @(negedge clk);
    chk("grabResults", 128'(grabResults), 128'(e_grab));
    chk("jobStartIgnored", 128'(jobStartIgnored), 128'(e_ign));
    chk("outValid", 128'(outValid), 128'(e_valid));
    chk("busy", 128'(busy), 128'(e_busy));
    chk("outSum", 128'(outSum), 128'(m_sum));
    chk("outCount", 128'(outCount), 128'(m_cnt));
    chk("outEcc", 128'(outEcc), 128'(m_ecc));
    last_valid = outValid;
    if (jobStartIgnored) n_ign++;
    if (grabResults) begin
      n_grabs++;
      grab_log.push_back(cyc);
      del_cyc = cyc + int'(GL);
      if (pk_sum.size() > 0) begin
        del_sum = pk_sum.pop_front();
        del_cnt = pk_cnt.pop_front();
        del_ecc = pk_ecc.pop_front();
      end else begin
        del_sum = rnd_sum();
        del_cnt = rnd_cnt();
        del_ecc = 1'($urandom_range(0, 1));
      end
    end
    if (s_rst && !rst) begin
      rst = 1'b1;
      #1;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_outValid", 128'(outValid), 128'(0));
      chk("rst_grab", 128'(grabResults), 128'(0));
      chk("rst_outSum", 128'(outSum), 128'(0));
      chk("rst_outCount", 128'(outCount), 128'(0));
      chk("rst_outEcc", 128'(outEcc), 128'(0));
    end
    rst = s_rst;
    jobStart = s_js;
    jobBatches = s_jb;
    resultsAvailable = s_av;
    outReady = s_rdy;
    if (cyc == del_cyc) begin
      pcoeffSum = del_sum; pcoeffCount = del_cnt; eccStatus = del_ecc;
    end else begin
      pcoeffSum = rnd_sum(); pcoeffCount = rnd_cnt(); eccStatus = 1'($urandom_range(0, 1));
    end
    model_step();
    cyc++;
  endtask

  task automatic start_job(input int b);
    s_js = 1'b1;
    s_jb = BATCH_W'(b);
    tick();
    s_js = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int maxc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick();
      seen = last_valid;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout cyc=%0d actual=no_outValid required=outValid", name, cyc);
    end
  endtask

  task automatic accept(input string name);
    s_rdy = 1'b1;
    tick();
    tick();
    chk({name, "_idle_busy"}, 128'(busy), 128'(0));
    chk({name, "_idle_valid"}, 128'(outValid), 128'(0));
  endtask

  initial begin
    int g0, sc, ig0;
    logic [OS_W-1:0] x_sum;
    logic [OC_W-1:0] x_cnt;

    #1;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_outValid", 128'(outValid), 128'(0));
    chk("reset_outSum", 128'(outSum), 128'(0));
    repeat (2) tick();
    s_rst = 1'b0;
    repeat (2) tick();

    // T1: single batch, avail arrives late
    s_rdy = 1'b0; s_av = 1'b0;
    push_pk(SUM_W'(100), COUNT_W'(7), 1'b0);
    g0 = n_grabs;
    start_job(1);
    repeat (4) tick();
    s_av = 1'b1;
    wait_valid("t1", 100);
    chk("t1_sum", 128'(outSum), 128'(100));
    chk("t1_cnt", 128'(outCount), 128'(7));
    chk("t1_ecc", 128'(outEcc), 128'(0));
    chk("t1_grabs", 128'(n_grabs - g0), 128'(1));
    accept("t1");
    s_rdy = 1'b0;

    // T2: three batches, avail held high, ECC on second capture
    push_pk(SUM_W'(1), COUNT_W'(10), 1'b0);
    push_pk(SUM_W'(2), COUNT_W'(20), 1'b1);
    push_pk(SUM_W'(3), COUNT_W'(30), 1'b0);
    grab_log.delete();
    start_job(3);
    wait_valid("t2", 200);
    chk("t2_sum", 128'(outSum), 128'(6));
    chk("t2_cnt", 128'(outCount), 128'(60));
    chk("t2_ecc", 128'(outEcc), 128'(1));
    chk("t2_grabs", 128'(grab_log.size()), 128'(3));
    for (int i = 0; i + 1 < grab_log.size(); i++)
      chk("t2_grab_spacing_ok", 128'((grab_log[i+1] - grab_log[i]) >= int'(H) + 1), 128'(1));
    accept("t2");

    // T3: zero-batch job
    s_rdy = 1'b1;
    g0 = n_grabs;
    sc = cyc;
    start_job(0);
    wait_valid("t3", 20);
    chk("t3_valid_delay", 128'(cyc - 1 - sc), 128'(2));
    chk("t3_sum", 128'(outSum), 128'(0));
    chk("t3_cnt", 128'(outCount), 128'(0));
    chk("t3_grabs", 128'(n_grabs - g0), 128'(0));
    repeat (2) tick();

    // T4: DONE stalled with a stray jobStart; jobStart during handshake
    s_rdy = 1'b0;
    push_pk(SUM_W'(55), COUNT_W'(4), 1'b1);
    start_job(1);
    wait_valid("t4", 100);
    ig0 = n_ign;
    for (int i = 0; i < 10; i++) begin
      s_js = (i == 3);
      s_jb = BATCH_W'(5);
      tick();
    end
    s_js = 1'b0;
    chk("t4_hold_valid", 128'(outValid), 128'(1));
    chk("t4_hold_sum", 128'(outSum), 128'(55));
    chk("t4_hold_cnt", 128'(outCount), 128'(4));
    chk("t4_hold_ecc", 128'(outEcc), 128'(1));
    chk("t4_ign_pulses", 128'(n_ign - ig0), 128'(1));
    s_js = 1'b1;
    s_rdy = 1'b1;
    tick();
    s_js = 1'b0;
    tick();
    chk("t4_idle_busy", 128'(busy), 128'(0));
    chk("t4_idle_valid", 128'(outValid), 128'(0));
    chk("t4_ign_pulses2", 128'(n_ign - ig0), 128'(2));
    repeat (2) tick();

    // T5: reset during LATENCY of batch 2 of 4, then a clean job
    s_av = 1'b1;
    for (int i = 0; i < 4; i++) push_pk(SUM_W'(1000 + i), COUNT_W'(50 + i), 1'b1);
    g0 = n_grabs;
    start_job(4);
    for (int i = 0; i < 100 && (n_grabs - g0) < 2; i++) tick();
    chk("t5_reached_batch2", 128'(n_grabs - g0), 128'(2));
    tick();
    s_rst = 1'b1;
    tick();
    tick();
    s_rst = 1'b0;
    tick();
    pk_sum.delete(); pk_cnt.delete(); pk_ecc.delete();
    repeat (3) tick();
    push_pk(SUM_W'(5), COUNT_W'(1), 1'b0);
    start_job(1);
    wait_valid("t5", 100);
    chk("t5_sum", 128'(outSum), 128'(5));
    chk("t5_cnt", 128'(outCount), 128'(1));
    chk("t5_ecc", 128'(outEcc), 128'(0));
    repeat (3) tick();

    // T6: full-scale values, no truncation
    push_pk({SUM_W{1'b1}}, {COUNT_W{1'b1}}, 1'b0);
    push_pk({SUM_W{1'b1}}, {COUNT_W{1'b1}}, 1'b0);
    start_job(2);
    wait_valid("t6", 200);
    x_sum = OS_W'({SUM_W{1'b1}}) << 1;
    x_cnt = OC_W'({COUNT_W{1'b1}}) << 1;
    chk("t6_sum", 128'(outSum), 128'(x_sum));
    chk("t6_cnt", 128'(outCount), 128'(x_cnt));
    repeat (2) tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s_js  = ($urandom_range(0, 19) == 0);
      s_jb  = BATCH_W'($urandom_range(0, 3));
      s_av  = 1'($urandom_range(0, 1));
      s_rdy = 1'($urandom_range(0, 1));
      s_rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    s_rst = 1'b0;
    s_js = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
